// File: rtl/lfsr_pkg.sv
// lfsr_pkg
//   Shared types and helpers for the lfsr_prng word source.
//   - lfsr_state_t : two-state control FSM (idle / running)
//   - LFSR_MAX_W   : widest LFSR the shift helper supports
//   - lfsr_shift() : one Fibonacci shift step on a zero-extended state
package lfsr_pkg;

  typedef enum logic {S_IDLE, S_RUN} lfsr_state_t;

  localparam int LFSR_MAX_W = 64;

  // One single shift: feedback is the parity of the tapped bits, shifted
  // in at bit 0. Callers zero-extend state/taps to LFSR_MAX_W and truncate
  // the result back to their own width, so bits above WIDTH never matter.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_shift(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    lfsr_shift = {state[LFSR_MAX_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step
//   Combinational STEP-fold unroll of the single LFSR shift, so the top can
//   advance several positions in one clock.
//   Ports:
//     state_i  in  WIDTH  current LFSR state
//     state_o  out WIDTH  state after STEP single shifts
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter int               STEP  = 1
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  // chain[k] holds the state after k single shifts
  logic [STEP:0][WIDTH-1:0] chain;

  assign chain[0] = state_i;

  for (genvar i = 0; i < STEP; i++) begin : g_shift
    assign chain[i+1] = WIDTH'(lfsr_shift(LFSR_MAX_W'(chain[i]), LFSR_MAX_W'(TAPS)));
  end

  assign state_o = chain[STEP];

endmodule

// File: rtl/lfsr_prng.sv
// lfsr_prng
//   Parametrised Fibonacci LFSR word source with a valid/ready output.
//   One word is delivered per accepted handshake; each accepted word advances
//   the LFSR by STEP single shifts. Zero seeds are replaced by DEFAULT_SEED,
//   an all-zero state in RUN is recovered and flagged, and a one-cycle wrap
//   pulse marks the return of the sequence to the loaded seed.
//   Optional build macro: LFSR_PERIOD_CNT_EN adds a word counter and the
//   period_len output (length of the last completed period).
//   Ports:
//     clk         in   1      rising-edge clock
//     reset       in   1      asynchronous active-high reset
//     load        in   1      load seed and enter RUN
//     seed        in   WIDTH  seed sampled when load=1
//     stop        in   1      return to IDLE, state held
//     rand_ready  in   1      consumer accepts rand_word
//     rand_valid  out  1      rand_word valid (RUN)
//     rand_word   out  WIDTH  current LFSR state
//     rand_bit    out  1      feedback bit of current state
//     wrap        out  1      pulse: last advance returned to the seed
//     lockup_err  out  1      sticky: all-zero state seen and recovered
//     period_len  out  WIDTH  (LFSR_PERIOD_CNT_EN only) words per period
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter int               STEP         = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             stop,
  input  logic             rand_ready,
  output logic             rand_valid,
  output logic [WIDTH-1:0] rand_word,
  output logic             rand_bit,
  output logic             wrap,
  output logic             lockup_err
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [WIDTH-1:0] period_len
`endif
);

  if (WIDTH < 3 || WIDTH > LFSR_MAX_W) begin : g_bad_width
    $error("lfsr_prng: WIDTH out of range");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("lfsr_prng: STEP must be 1..WIDTH");
  end
  if (DEFAULT_SEED == '0) begin : g_bad_seed
    $error("lfsr_prng: DEFAULT_SEED must be nonzero");
  end

  lfsr_state_t      fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] step_out;
  logic [WIDTH-1:0] load_val;
  logic             handshake;
  logic             adv_en;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEP  (STEP)
  ) u_step (
    .state_i (state_q),
    .state_o (step_out)
  );

  assign handshake = (fsm_q == S_RUN) && rand_ready;
  // A zero seed would lock the LFSR, so it is replaced up front.
  assign load_val  = (seed == '0) ? DEFAULT_SEED : seed;

  // Priority: load > stop > lock-up recovery > handshake advance. A handshake
  // coincident with load or stop still delivers the old word, it just does
  // not advance the state.
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    seed_d   = seed_q;
    wrap_d   = 1'b0;
    lockup_d = lockup_q;
    adv_en   = 1'b0;
    if (load) begin
      fsm_d    = S_RUN;
      state_d  = load_val;
      seed_d   = load_val;
      lockup_d = 1'b0;
    end else if (stop) begin
      fsm_d = S_IDLE;
    end else if (fsm_q == S_RUN && state_q == '0) begin
      // Only reachable through an upset or degenerate taps; recover without
      // a wrap pulse and leave the valid asserted.
      state_d  = DEFAULT_SEED;
      lockup_d = 1'b1;
    end else if (handshake) begin
      state_d = step_out;
      wrap_d  = (step_out == seed_q);
      adv_en  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q    <= S_IDLE;
      state_q  <= DEFAULT_SEED;
      seed_q   <= DEFAULT_SEED;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      seed_q   <= seed_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign rand_valid = (fsm_q == S_RUN);
  assign rand_word  = state_q;
  assign rand_bit   = ^(state_q & TAPS);
  assign wrap       = wrap_q;
  assign lockup_err = lockup_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;

  // cnt_q counts words accepted since the last load/wrap; the wrapping word
  // itself completes the period, hence the +1 on capture.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (load) begin
      cnt_d = '0;
    end else if (adv_en) begin
      if (wrap_d) begin
        period_d = cnt_q + WIDTH'(1);
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign period_len = period_q;
`endif

endmodule
